// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants and types for the small neural-network slice.
//   NUM_NEURONS : default number of hidden neurons sequenced per pass
//   NUM_INPUTS  : width of the input vector x (one weight per input)
//   W_WIDTH     : weight width, unsigned 1.7 fixed point
//   ACC_WIDTH   : width of one hidden_neuron result
//   seq_state_t : hidden-layer sequencer FSM encoding
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_INPUTS  = 4;
    localparam int W_WIDTH     = 8;
    localparam int ACC_WIDTH   = 10;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_ISSUE   = 2'd1,
        SEQ_CAPTURE = 2'd2,
        SEQ_DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/hidden_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// hidden_layer_sequencer_if
// Groups the two buses of the hidden-layer sequencer:
//   neuron side : nrn_en, nrn_x, nrn_w0..nrn_w3 towards hidden_neuron,
//                 nrn_result back from its output register
//   stream side : h_valid, h_idx, h_data towards the output layer
// Modports:
//   master : the sequencer (drives everything except nrn_result)
//   slave  : the neuron datapath / output layer side
// -----------------------------------------------------------------------------
interface hidden_layer_sequencer_if #(
    parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
    parameter int W_WIDTH     = nn_pkg::W_WIDTH,
    parameter int ACC_WIDTH   = nn_pkg::ACC_WIDTH
);

    localparam int IDX_W = $clog2(NUM_NEURONS);

    logic                 nrn_en;
    logic [3:0]           nrn_x;
    logic [W_WIDTH-1:0]   nrn_w0;
    logic [W_WIDTH-1:0]   nrn_w1;
    logic [W_WIDTH-1:0]   nrn_w2;
    logic [W_WIDTH-1:0]   nrn_w3;
    logic [ACC_WIDTH-1:0] nrn_result;

    logic                 h_valid;
    logic [IDX_W-1:0]     h_idx;
    logic [ACC_WIDTH-1:0] h_data;

    modport master (
        output nrn_en, nrn_x, nrn_w0, nrn_w1, nrn_w2, nrn_w3,
        input  nrn_result,
        output h_valid, h_idx, h_data
    );

    modport slave (
        input  nrn_en, nrn_x, nrn_w0, nrn_w1, nrn_w2, nrn_w3,
        output nrn_result,
        input  h_valid, h_idx, h_data
    );

endinterface

// File: rtl/hidden_layer_sequencer_weight_bank.sv
// -----------------------------------------------------------------------------
// weight_bank
// NUM_NEURONS entries of {w3,w2,w1,w0}; synchronous write, asynchronous read,
// asynchronous active-low clear of every entry.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low clear
//   wr_en_i   : write wr_data_i into entry wr_addr_i this cycle
//   wr_addr_i : entry to write; out-of-range addresses are dropped
//   wr_data_i : {w3,w2,w1,w0}
//   rd_addr_i : entry to read combinationally
//   rd_data_o : contents of entry rd_addr_i (zero when out of range)
// -----------------------------------------------------------------------------
module weight_bank #(
    parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
    parameter int W_WIDTH     = nn_pkg::W_WIDTH,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_addr_i,
    input  logic [4*W_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]     rd_addr_i,
    output logic [4*W_WIDTH-1:0] rd_data_o
);

    logic [4*W_WIDTH-1:0] bank_q [NUM_NEURONS];
    logic                 wr_in_range;
    logic                 rd_in_range;

    // Addresses are widened before comparing so the range check stays
    // meaningful when NUM_NEURONS is not a power of two.
    assign wr_in_range = (32'(wr_addr_i) < 32'(NUM_NEURONS));
    assign rd_in_range = (32'(rd_addr_i) < 32'(NUM_NEURONS));

    // Storage: cleared as a whole on reset, one entry written per cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en_i && wr_in_range) begin
            bank_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read so the current neuron's weights are ready in ISSUE.
    assign rd_data_o = rd_in_range ? bank_q[rd_addr_i] : '0;

endmodule

// File: rtl/hidden_layer_sequencer.sv
// -----------------------------------------------------------------------------
// hidden_layer_sequencer
// Time-multiplexes one hidden_neuron datapath across NUM_NEURONS neurons.
// Each neuron takes an ISSUE cycle (enable + weights to the neuron) and a
// CAPTURE cycle (registered neuron result streamed out with its index); a
// single DONE cycle closes the pass.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-low reset
//   wload_en_i   : write one neuron's weight set (honoured in IDLE/DONE only)
//   wload_addr_i : neuron index to write
//   wload_data_i : {w3,w2,w1,w0}
//   start_i      : begin a pass, sampled only in IDLE
//   x_i          : input vector, latched when start is accepted
//   busy_o       : pass in progress (ISSUE/CAPTURE)
//   done_o       : one-cycle pulse after the last result
//   bus          : neuron datapath and h-stream signals (master side)
// -----------------------------------------------------------------------------
module hidden_layer_sequencer #(
    parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
    parameter int W_WIDTH     = nn_pkg::W_WIDTH,
    parameter int ACC_WIDTH   = nn_pkg::ACC_WIDTH,
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wload_en_i,
    input  logic [IDX_W-1:0]         wload_addr_i,
    input  logic [4*W_WIDTH-1:0]     wload_data_i,
    input  logic                     start_i,
    input  logic [3:0]               x_i,
    output logic                     busy_o,
    output logic                     done_o,
    hidden_layer_sequencer_if.master bus
);

    import nn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [3:0]           x_q;
    logic [IDX_W-1:0]     h_idx_q;
    logic [ACC_WIDTH-1:0] h_data_q;
    logic                 in_idle;
    logic                 in_capture;
    logic                 start_accept;
    logic                 bank_we;
    logic [4*W_WIDTH-1:0] cur_w;

    assign in_idle      = (state_q == SEQ_IDLE);
    assign in_capture   = (state_q == SEQ_CAPTURE);
    assign start_accept = in_idle && start_i;

    // Writes are locked out while busy so bank[idx] cannot change under a
    // running pass; a write alongside an accepted start still commits and
    // the first ISSUE reads the new value.
    assign bank_we = wload_en_i && (in_idle || (state_q == SEQ_DONE));

    weight_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .W_WIDTH     (W_WIDTH),
        .IDX_W       (IDX_W)
    ) u_weight_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (bank_we),
        .wr_addr_i (wload_addr_i),
        .wr_data_i (wload_data_i),
        .rd_addr_i (idx_q),
        .rd_data_o (cur_w)
    );

    // State, index, input latch and held h-stream values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= SEQ_IDLE;
            idx_q    <= '0;
            x_q      <= '0;
            h_idx_q  <= '0;
            h_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (start_accept) begin
                x_q <= x_i;
            end
            if (in_capture) begin
                h_idx_q  <= idx_q;
                h_data_q <= bus.nrn_result;
            end
        end
    end

    // Next state and index. The index only returns to zero on DONE->IDLE,
    // so it never has to wrap on its own.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                state_d = SEQ_CAPTURE;
            end
            SEQ_CAPTURE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = SEQ_DONE;
                end else begin
                    state_d = SEQ_ISSUE;
                    idx_d   = idx_q + 1'b1;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = SEQ_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decode the registered state. The neuron result is registered
    // inside hidden_neuron, so it is already valid during CAPTURE and is
    // passed straight out then; outside CAPTURE the captured copy is held.
    assign busy_o      = (state_q == SEQ_ISSUE) || in_capture;
    assign done_o      = (state_q == SEQ_DONE);

    assign bus.nrn_en  = (state_q == SEQ_ISSUE);
    assign bus.nrn_x   = x_q;
    assign bus.nrn_w0  = cur_w[0*W_WIDTH +: W_WIDTH];
    assign bus.nrn_w1  = cur_w[1*W_WIDTH +: W_WIDTH];
    assign bus.nrn_w2  = cur_w[2*W_WIDTH +: W_WIDTH];
    assign bus.nrn_w3  = cur_w[3*W_WIDTH +: W_WIDTH];

    assign bus.h_valid = in_capture;
    assign bus.h_idx   = in_capture ? idx_q : h_idx_q;
    assign bus.h_data  = in_capture ? bus.nrn_result : h_data_q;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hidden_layer_sequencer
// Drives the sequencer with a behavioural hidden_neuron attached, keeps its
// own copy of the weight bank, and compares every streamed result against a
// queue of expected {idx, data} pairs filled when each pass is started.
// -----------------------------------------------------------------------------
module tb_hidden_layer_sequencer;

    localparam int N      = 4;
    localparam int WW     = 8;
    localparam int AW     = 10;
    localparam int IW     = 2;
    localparam int PASS_LATENCY = 2 * N + 1;

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] data;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            wload_en;
    logic [IW-1:0]   wload_addr;
    logic [4*WW-1:0] wload_data;
    logic            start;
    logic [3:0]      x;
    logic            busy;
    logic            done;

    logic [4*WW-1:0] w_model [N];
    exp_t            exp_q [$];
    exp_t            mon_e;

    int num_checks = 0;
    int num_fails  = 0;

    hidden_layer_sequencer_if #(
        .NUM_NEURONS (N),
        .W_WIDTH     (WW),
        .ACC_WIDTH   (AW)
    ) bus ();

    hidden_layer_sequencer #(
        .NUM_NEURONS (N),
        .W_WIDTH     (WW),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .wload_en_i   (wload_en),
        .wload_addr_i (wload_addr),
        .wload_data_i (wload_data),
        .start_i      (start),
        .x_i          (x),
        .busy_o       (busy),
        .done_o       (done),
        .bus          (bus)
    );

    // Behavioural hidden_neuron: registered sum of the weights whose input
    // bit is set, updated only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.nrn_result <= '0;
        end else if (bus.nrn_en) begin
            bus.nrn_result <= (bus.nrn_x[0] ? AW'(bus.nrn_w0) : '0)
                            + (bus.nrn_x[1] ? AW'(bus.nrn_w1) : '0)
                            + (bus.nrn_x[2] ? AW'(bus.nrn_w2) : '0)
                            + (bus.nrn_x[3] ? AW'(bus.nrn_w3) : '0);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result of one neuron computed from the bench's weight copy.
    function automatic logic [AW-1:0] expected_result(input logic [4*WW-1:0] w,
                                                      input logic [3:0] xv);
        logic [AW-1:0] acc;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            if (xv[k]) acc = acc + AW'(w[k*WW +: WW]);
        end
        return acc;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: every h_valid cycle must match the oldest entry.
    always @(negedge clk) begin
        if (rst_n && bus.h_valid) begin
            if (exp_q.size() == 0) begin
                check_output("h_valid_unexpected", 64'(bus.h_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("h_idx", 64'(bus.h_idx), 64'(mon_e.idx));
                check_output("h_data", 64'(bus.h_data), 64'(mon_e.data));
            end
        end
    end

    task automatic push_expected(input logic [3:0] xv);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.idx  = IW'(i);
            e.data = expected_result(w_model[i], xv);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic apply_stimulus(input logic [IW-1:0] addr, input logic [4*WW-1:0] data);
        wload_en   = 1'b1;
        wload_addr = addr;
        wload_data = data;
        @(posedge clk);
        w_model[addr] = data;
        #1 wload_en = 1'b0;
    endtask

    // Called at posedge+1 (possibly with a write already driven); returns
    // one step after the accepting edge.
    task automatic start_pass(input logic [3:0] xv);
        x     = xv;
        start = 1'b1;
        @(posedge clk);
        push_expected(xv);
        #1;
        start    = 1'b0;
        wload_en = 1'b0;
    endtask

    // Waits for done_o counting cycles from the accepting edge; returns at
    // the negedge of the IDLE cycle after DONE.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check_output({tag, "_done_latency"}, 64'(lat), 64'(PASS_LATENCY));
        check_output({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_output({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check_output({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({busy, done, bus.nrn_en, bus.nrn_x, bus.nrn_w3, bus.nrn_w2,
                    bus.nrn_w1, bus.nrn_w0, bus.h_valid, bus.h_idx, bus.h_data});
    endfunction

    initial begin
        bit found;
        rst_n      = 1'b0;
        wload_en   = 1'b0;
        wload_addr = '0;
        wload_data = '0;
        start      = 1'b0;
        x          = '0;
        for (int i = 0; i < N; i++) w_model[i] = '0;

        // Reset, then five idle cycles with every output at zero.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("idle_outputs", all_outputs(), 64'd0);
        end

        // Load weights and run with all inputs set.
        @(posedge clk); #1;
        apply_stimulus(2'd0, 32'h4030_2010);
        apply_stimulus(2'd1, 32'h0808_0808);
        apply_stimulus(2'd2, 32'h0808_0808);
        apply_stimulus(2'd3, 32'h0808_0808);
        start_pass(4'b1111);
        wait_done("pass_1111");

        // Same weights, sparse input pattern.
        @(posedge clk); #1;
        start_pass(4'b0101);
        wait_done("pass_0101");

        // start held high through the pass: one pass, then the next begins
        // from the IDLE cycle after DONE.
        @(posedge clk); #1;
        x     = 4'b0011;
        start = 1'b1;
        @(posedge clk);
        push_expected(4'b0011);
        wait_done("held_first");
        check_output("held_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        push_expected(4'b0011);
        #1 start = 1'b0;
        @(negedge clk);
        check_output("held_second_busy", 64'(busy), 64'd1);
        for (int c = 0; c < 40 && !done; c++) @(negedge clk);
        check_output("held_second_done", 64'(done), 64'd1);
        @(negedge clk);
        check_output("held_second_drained", 64'(exp_q.size()), 64'd0);

        // A write during the pass is ignored.
        @(posedge clk); #1;
        start_pass(4'b1111);
        fork
            begin
                @(posedge clk); #1;
                wload_en   = 1'b1;
                wload_addr = 2'd2;
                wload_data = 32'h7F7F_7F7F;
                @(posedge clk); #1;
                wload_en   = 1'b0;
            end
            wait_done("midpass_write");
        join

        // Write in IDLE together with start: the pass uses the new weights.
        @(posedge clk); #1;
        wload_en   = 1'b1;
        wload_addr = 2'd2;
        wload_data = 32'h7F7F_7F7F;
        w_model[2] = 32'h7F7F_7F7F;
        start_pass(4'b1111);
        wait_done("idle_write");

        // Reset during CAPTURE of neuron 1.
        @(posedge clk); #1;
        start_pass(4'b1111);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.h_valid && bus.h_idx == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check_output("reached_capture_1", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_drop", 64'({busy, bus.h_valid, done, bus.nrn_en}), 64'd0);
        check_output("reset_bank_clear",
                     64'({bus.nrn_w3, bus.nrn_w2, bus.nrn_w1, bus.nrn_w0}), 64'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) w_model[i] = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start_pass(4'b1111);
        wait_done("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
